mac_result_packer: RTL and testbench
====================================

# mac_result_packer

Downstream stage of the 8-bit signed MAC. On a snapshot request it captures the 24-bit accumulator value. It then emits the value over a byte-wide valid/ready stream, in one of two forms: three raw bytes, least significant byte first, or one byte requantized (round-to-nearest and saturate). This replaces the MAC's static byte-select readout with a flow-controlled result path toward the I/O pins or a host interface.

## Interface
Parameters:
- ACC_W, 24, accumulator width; must match the MAC accumulator.
- OUT_W, 8, output byte width; fixed at 8 for this design.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- acc_in  in  24  live accumulator value from the MAC, signed two's complement.
- snap  in  1  capture request, sampled every cycle.
- mode  in  1  0 = raw 3-byte, 1 = requantized 1-byte; sampled together with an accepted snap.
- shift  in  4  requantization right-shift amount, 0..15; sampled together with an accepted snap.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  consumer accepts the byte; a transfer occurs when out_valid and out_ready are both high.
- busy  out  1  high in any state other than IDLE.
- sat  out  1  last requantized value was clipped; sticky until the next accepted snap.
- drop  out  1  a snap arrived while busy; sticky until the next accepted snap.

## Operation
- States:
  - IDLE: no snapshot pending.
  - SEND: a byte is being offered; byte index idx is 0..2.
- IDLE → SEND on snap:
  - Register acc_in, mode and shift.
  - Clear sat and drop.
  - Set idx = 0.
  - In mode 1, compute the requantized byte from acc_in in this same cycle, register it, and update sat.
- Stream contents:
  - Mode 0 emits 3 bytes: acc[7:0], then acc[15:8], then acc[23:16].
  - Mode 1 emits 1 byte: the requantized value.
- SEND on a transfer:
  - If the transferred byte is the last one, go to IDLE.
  - Otherwise increment idx.
- Requantization arithmetic, in a 25-bit signed intermediate:
  - r = acc + (shift == 0 ? 0 : 1 << (shift−1)), then arithmetic right shift by shift.
  - If r > 127, output 0x7F and set sat.
  - If r < −128, output 0x80 and set sat.
  - Otherwise output r[7:0].
- Tie rounding is half-up toward +∞. For example, −8 with shift 4 gives −0.5, which rounds to 0.
- snap while busy, including the cycle of the final transfer:
  - The snap is ignored and drop is set.
  - Captured data, mode and shift are unaffected.
- mode and shift changes outside an accepted snap have no effect.
- acc_in is never re-read during SEND. Later accumulation by the MAC does not alter the bytes in flight.

## Timing
- Reset values: out_data = 0x00, out_valid = 0, busy = 0, sat = 0, drop = 0; state IDLE, idx 0, capture registers zero.
- Reset mid-stream aborts the stream immediately. out_valid is low in the cycle after rst is sampled high, and no partial stream resumes.
- Latency: snap sampled at edge N → out_valid = 1 and first byte on out_data from edge N until its transfer.
- Back-to-back bytes: one byte per cycle while out_ready is held high. A mode 0 stream therefore completes in 3 cycles.
- While out_valid = 1 and out_ready = 0, out_data and out_valid hold stable.
- out_valid never drops without a transfer, except on rst.
- After the final transfer at edge M, busy = 0 and out_valid = 0 from edge M. The earliest accepted snap is the one sampled at edge M+1.
- out_ready is ignored while out_valid = 0.

## Structure
- Shared package mac_pkg holds:
  - ACC_W and OUT_W constants.
  - State type {IDLE, SEND}.
  - Mode constants MODE_RAW = 0 and MODE_QUANT = 1.
- Sub-module mac_requant is purely combinational:
  - Inputs: acc[23:0], shift[3:0].
  - Outputs: q[7:0], sat.
  - It is tested standalone and instantiated once.
- Top-level FSM, byte counter, capture registers and sticky flags live in mac_result_packer.

## Test plan
- Raw stream: acc_in = 0x030201, mode 0, snap, out_ready held high → bytes 0x01, 0x02, 0x03 on 3 consecutive cycles, then out_valid = 0 and busy = 0.
- Requantize with rounding:
  - acc 0x000038 (56), shift 4 → 0x04.
  - acc 0xFFFFC8 (−56), shift 4 → 0xFD (−3).
  - acc 0xFFFFF8 (−8), shift 4 → 0x00.
  - sat = 0 in all three cases.
- Saturation:
  - acc 0x001000, shift 4 → 0x7F, sat = 1.
  - acc 0xFFF000, shift 4 → 0x80, sat = 1.
  - acc 0x00007F, shift 0 → 0x7F, sat = 0.
- Backpressure: mode 0, acc 0xA5B6C7, out_ready low for 3 cycles on each byte → 0xC7 held stable, then 0xB6, then 0xA5. No byte is lost or duplicated.
- Snapshot isolation and drop:
  - Change acc_in every cycle during a stream → emitted bytes equal the value captured at snap.
  - Snap during SEND → drop = 1 and the stream is unchanged.
  - The next accepted snap clears drop.
- Reset mid-stream: assert rst after the first byte of a mode 0 stream → all outputs return to their reset values. A following snap of 0x000010 yields 0x10, 0x00, 0x00.

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Definitions shared by the MAC result path: the accumulator and output
// widths, the packer state type and the stream mode encodings.
// -----------------------------------------------------------------------------
package mac_pkg;

    // Accumulator width. It must match the MAC accumulator.
    localparam int ACC_W   = 24;
    // Output stream byte width.
    localparam int OUT_W   = 8;
    // Number of bytes in a raw stream.
    localparam int N_BYTES = ACC_W / OUT_W;

    // Packer states. IDLE means no snapshot is pending. SEND means a byte
    // is currently on offer.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Stream modes, sampled together with an accepted snap.
    localparam logic MODE_RAW   = 1'b0;   // three raw bytes, LSB first
    localparam logic MODE_QUANT = 1'b1;   // one rounded, saturated byte

endpackage

// File: rtl/mac_requant.sv
// -----------------------------------------------------------------------------
// mac_requant
// Purely combinational requantizer. It scales a signed accumulator value down
// to one signed byte: first it rounds to nearest (ties go toward +inf), then
// it saturates to the int8 range.
//
// Ports:
//   acc    in   ACC_W  signed accumulator value
//   shift  in   4      right-shift amount, 0..15
//   q      out  OUT_W  requantized byte
//   sat    out  1      result was clipped to 0x7F or 0x80
// -----------------------------------------------------------------------------
module mac_requant
    import mac_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       shift,
    output logic [OUT_W-1:0] q,
    output logic             sat
);

    // One extra bit so that adding the rounding bias to the most positive
    // accumulator value cannot overflow.
    localparam int MID_W = ACC_W + 1;

    localparam logic signed [MID_W-1:0] Q_MAX = MID_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [MID_W-1:0] Q_MIN = -MID_W'(2 ** (OUT_W - 1));

    logic signed [MID_W-1:0] acc_ext;
    logic signed [MID_W-1:0] bias;
    logic signed [MID_W-1:0] sum;
    logic signed [MID_W-1:0] r;

    always_comb begin
        // NOTE: every output of a combinational block gets a default value
        // first. A path that leaves a variable unassigned would infer a latch.
        bias = '0;
        q    = '0;
        sat  = 1'b0;

        acc_ext = {acc[ACC_W-1], acc};

        // Adding half an LSB of the result before the arithmetic shift gives
        // round-half-up. The shift floors toward -inf, so -0.5 becomes 0.
        if (shift != 4'd0) begin
            bias = MID_W'(1) << (shift - 4'd1);
        end

        sum = acc_ext + bias;
        r   = sum >>> shift;

        if (r > Q_MAX) begin
            q   = Q_MAX[OUT_W-1:0];
            sat = 1'b1;
        end else if (r < Q_MIN) begin
            q   = Q_MIN[OUT_W-1:0];
            sat = 1'b1;
        end else begin
            q   = r[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/mac_result_packer.sv
// -----------------------------------------------------------------------------
// mac_result_packer
// Captures the MAC accumulator on a snapshot request and streams the value
// out over a byte-wide valid/ready interface. The value goes out either as
// three raw bytes (LSB first) or as one requantized byte.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   acc_in     in   ACC_W  live accumulator from the MAC (signed)
//   snap       in   1      capture request, sampled every cycle
//   mode       in   1      0 = raw 3-byte, 1 = requantized 1-byte (on snap)
//   shift      in   4      requantization shift, 0..15 (on snap)
//   out_data   out  OUT_W  stream byte
//   out_valid  out  1      out_data holds a valid byte
//   out_ready  in   1      consumer accepts the byte
//   busy       out  1      a stream is in progress
//   sat        out  1      last requantized value was clipped (sticky)
//   drop       out  1      a snap arrived while busy (sticky)
// -----------------------------------------------------------------------------
module mac_result_packer
    import mac_pkg::state_t, mac_pkg::IDLE, mac_pkg::SEND,
           mac_pkg::MODE_RAW, mac_pkg::MODE_QUANT, mac_pkg::N_BYTES;
#(
    parameter int ACC_W = mac_pkg::ACC_W,
    parameter int OUT_W = mac_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] acc_in,
    input  logic             snap,
    input  logic             mode,
    input  logic [3:0]       shift,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             sat,
    output logic             drop
);

    localparam logic [1:0] LAST_IDX = 2'(N_BYTES - 1);

    state_t           state;
    state_t           state_next;
    logic [1:0]       idx;
    logic [1:0]       idx_next;

    // Capture registers. The requantized byte is computed from the live
    // acc_in in the snap cycle. Because of that, shift never has to be held
    // past the capture.
    logic [ACC_W-1:0] acc_reg;
    logic             mode_reg;
    logic [OUT_W-1:0] quant_reg;
    logic             sat_reg;
    logic             drop_reg;

    logic [OUT_W-1:0] req_q;
    logic             req_sat;

    logic             accept;
    logic             xfer;
    logic             last_byte;

    mac_requant u_requant (
        .acc   (acc_in),
        .shift (shift),
        .q     (req_q),
        .sat   (req_sat)
    );

    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign sat       = sat_reg;
    assign drop      = drop_reg;

    // A snap is accepted only in IDLE. That includes the cycle after the
    // final transfer, but not the cycle of the final transfer itself.
    assign accept    = snap && (state == IDLE);
    assign xfer      = out_valid && out_ready;
    assign last_byte = (mode_reg == MODE_QUANT) || (idx == LAST_IDX);

    // Next-state and byte-index logic.
    always_comb begin
        state_next = state;
        idx_next   = idx;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SEND;
                    idx_next   = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (last_byte) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next   = idx + 2'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Output byte select. All of it comes from captured registers, so the
    // byte holds stable under backpressure. It reads zero while idle.
    always_comb begin
        out_data = '0;

        if (state == SEND) begin
            if (mode_reg == MODE_QUANT) begin
                out_data = quant_reg;
            end else begin
                unique case (idx)
                    2'd0:    out_data = acc_reg[OUT_W-1:0];
                    2'd1:    out_data = acc_reg[2*OUT_W-1:OUT_W];
                    default: out_data = acc_reg[3*OUT_W-1:2*OUT_W];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from values sampled before the edge.
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            // NOTE: the capture registers are reset as well. This makes the
            // idle outputs well defined and keeps stale data from being
            // visible after reset.
            acc_reg   <= '0;
            mode_reg  <= MODE_RAW;
            quant_reg <= '0;
            sat_reg   <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;

            if (accept) begin
                acc_reg   <= acc_in;
                mode_reg  <= mode;
                quant_reg <= (mode == MODE_QUANT) ? req_q : '0;
                sat_reg   <= (mode == MODE_QUANT) && req_sat;
                drop_reg  <= 1'b0;
            end else if (snap) begin
                // A snap that is not accepted means the packer was busy. The
                // captured data is left alone.
                drop_reg  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_result_packer.sv
// -----------------------------------------------------------------------------
// tb_mac_result_packer
// Self-checking bench for mac_result_packer. Directed cases come first, then
// randomized snapshots under random backpressure and input noise. Each
// stream is compared against a reference model that computes the expected
// bytes from real-valued rounding and clipping.
// -----------------------------------------------------------------------------
module tb_mac_result_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] acc_in;
    logic        snap;
    logic        mode;
    logic [3:0]  shift;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        sat;
    logic        drop;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic       exp_sat;

    mac_result_packer dut (
        .clk       (clk),
        .rst       (rst),
        .acc_in    (acc_in),
        .snap      (snap),
        .mode      (mode),
        .shift     (shift),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .sat       (sat),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge. Outputs are then sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: build the expected byte stream and sat flag.
    task automatic model(input logic [23:0] a, input logic m, input logic [3:0] s);
        int  v;
        int  r;
        real scale;
        exp_q.delete();
        exp_sat = 1'b0;
        if (m == 1'b0) begin
            exp_q.push_back(a[7:0]);
            exp_q.push_back(a[15:8]);
            exp_q.push_back(a[23:16]);
        end else begin
            v     = int'($signed(a));
            scale = 1.0;
            for (int i = 0; i < int'(s); i++) scale = scale * 2.0;
            r = $rtoi($floor(real'(v) / scale + 0.5));
            if (r > 127) begin
                exp_q.push_back(8'h7F);
                exp_sat = 1'b1;
            end else if (r < -128) begin
                exp_q.push_back(8'h80);
                exp_sat = 1'b1;
            end else begin
                exp_q.push_back(r[7:0]);
            end
        end
    endtask

    // Snap one value and drain the stream. Each byte is stalled for
    // smin..smax cycles. When noise is set, acc_in, mode and shift are
    // scrambled every cycle, and snaps are issued while busy (always on the
    // first stream cycle).
    task automatic run_stream(input logic [23:0] a, input logic m, input logic [3:0] s,
                              input int smin, input int smax, input bit noise);
        int  stall_left;
        int  cycles;
        int  n_bytes;
        bit  exp_drop;
        bit  first;
        logic ready;

        model(a, m, s);
        n_bytes   = exp_q.size();
        acc_in    = a;
        mode      = m;
        shift     = s;
        snap      = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        cycle();
        snap = 1'b0;
        check("capture_sat", sat, exp_sat);
        check("capture_drop", drop, 1'b0);

        exp_drop   = 1'b0;
        first      = 1'b1;
        cycles     = 0;
        stall_left = $urandom_range(smin, smax);
        while (exp_q.size() > 0 && cycles < 100) begin
            check("stream_valid", out_valid, 1'b1);
            check("stream_busy", busy, 1'b1);
            check("stream_data", out_data, exp_q[0]);
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = 1'b1;
            end
            out_ready = ready;
            if (noise) begin
                acc_in = 24'($urandom);
                mode   = 1'($urandom_range(0, 1));
                shift  = 4'($urandom_range(0, 15));
                snap   = first ? 1'b1 : 1'($urandom_range(0, 1));
                if (snap) exp_drop = 1'b1;
            end
            first = 1'b0;
            cycle();
            cycles++;
            if (ready) begin
                void'(exp_q.pop_front());
                stall_left = $urandom_range(smin, smax);
            end
        end
        if (exp_q.size() > 0) check("stream_timeout", 1, 0);
        if (smax == 0) check("stream_cycles", cycles, n_bytes);

        snap      = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        check("done_valid", out_valid, 1'b0);
        check("done_busy", busy, 1'b0);
        check("done_data", out_data, 8'h00);
        check("done_sat", sat, exp_sat);
        check("done_drop", drop, exp_drop);
    endtask

    initial begin
        rst       = 1'b1;
        acc_in    = '0;
        snap      = 1'b0;
        mode      = 1'b0;
        shift     = '0;
        out_ready = 1'b0;
        cycle();
        cycle();
        check("reset_data", out_data, 8'h00);
        check("reset_valid", out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_sat", sat, 1'b0);
        check("reset_drop", drop, 1'b0);
        rst = 1'b0;
        cycle();
        check("idle_valid", out_valid, 1'b0);

        // Raw stream, back to back.
        run_stream(24'h030201, 1'b0, 4'd0, 0, 0, 1'b0);
        // Requantize with rounding.
        run_stream(24'h000038, 1'b1, 4'd4, 0, 0, 1'b0);
        run_stream(24'hFFFFC8, 1'b1, 4'd4, 0, 0, 1'b0);
        run_stream(24'hFFFFF8, 1'b1, 4'd4, 0, 0, 1'b0);
        // Saturation boundaries.
        run_stream(24'h001000, 1'b1, 4'd4, 0, 0, 1'b0);
        run_stream(24'hFFF000, 1'b1, 4'd4, 0, 0, 1'b0);
        run_stream(24'h00007F, 1'b1, 4'd0, 0, 0, 1'b0);
        run_stream(24'h000080, 1'b1, 4'd0, 0, 0, 1'b0);
        run_stream(24'hFFFF80, 1'b1, 4'd0, 0, 0, 1'b0);
        run_stream(24'h7FFFFF, 1'b1, 4'd15, 0, 0, 1'b0);
        run_stream(24'h800000, 1'b1, 4'd15, 0, 0, 1'b0);
        // Backpressure, three stall cycles on each byte.
        run_stream(24'hA5B6C7, 1'b0, 4'd0, 3, 3, 1'b0);
        // Snapshot isolation and drop, then a clean snap that clears drop.
        run_stream(24'h5A3C96, 1'b0, 4'd0, 0, 2, 1'b1);
        run_stream(24'h00FF00, 1'b0, 4'd0, 0, 0, 1'b0);

        // Reset mid-stream: one byte is transferred, drop is set, then reset.
        acc_in    = 24'h123456;
        mode      = 1'b0;
        shift     = 4'd0;
        snap      = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("mid_valid", out_valid, 1'b1);
        check("mid_data0", out_data, 8'h56);
        cycle();
        snap      = 1'b0;
        check("mid_drop", drop, 1'b1);
        check("mid_data1", out_data, 8'h34);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_data", out_data, 8'h00);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sat", sat, 1'b0);
        check("rst_drop", drop, 1'b0);
        cycle();
        check("rst_no_resume", out_valid, 1'b0);
        run_stream(24'h000010, 1'b0, 4'd0, 0, 0, 1'b0);

        // Randomized streams.
        for (int k = 0; k < 80; k++) begin
            run_stream(24'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       0, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
